// File: rtl/init_sequencer.sv
// rtl/init_sequencer.sv - power-up settle then NUM_STEPS req/ack config steps with timeout, retry and re-init
// INIT stays high until every step has been acknowledged; it gates the audio datapath.
module init_sequencer #(
  parameter int NUM_STEPS   = 10,
  parameter int IDX_W       = 4,
  parameter int PWR_CYC     = 1000,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Step_Ack,
  input  logic             Step_Err,
  output logic             Step_Req,
  output logic [IDX_W-1:0] Step_Idx,
  output logic             INIT,
  output logic             Init_Done,
  output logic             Init_Fail,
  output logic [1:0]       Retry_Cnt
);

  localparam int CNT_MAX_A = (PWR_CYC > GAP_CYC) ? PWR_CYC : GAP_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [31:0] PWR_L   = PWR_CYC;
  localparam logic [31:0] GAP_L   = GAP_CYC;
  localparam logic [31:0] TO_L    = TIMEOUT_CYC;
  localparam logic [31:0] RETRY_L = MAX_RETRY;

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    WAIT_ACK,
    GAP,
    DONE,
    FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               step_req_q, step_req_d;
  logic               init_q, init_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [1:0]         retry_cnt_q, retry_cnt_d;

  logic [31:0]        cnt_next_ext;
  logic               pwr_last, gap_last, to_last, idx_last;

  // Terminal tests use cnt+1 so a parameter of 0 or 1 still leaves the state after one cycle.
  always_comb begin
    cnt_next_ext = 32'(cnt_q) + 32'd1;
    pwr_last     = (cnt_next_ext >= PWR_L);
    gap_last     = (cnt_next_ext >= GAP_L);
    to_last      = (cnt_next_ext >= TO_L);
    idx_last     = (idx_q == IDX_W'(NUM_STEPS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    case (state_q)
      PWR_WAIT: begin
        if (pwr_last) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (Step_Err || (!Step_Ack && to_last)) begin
          cnt_d = '0;
          if (32'(retry_q) < RETRY_L) begin
            retry_d = retry_q + 1'b1;
            state_d = GAP;
          end else begin
            state_d = FAIL;
          end
        end else if (Step_Ack) begin
          cnt_d   = '0;
          retry_d = '0;
          if (idx_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE, FAIL: begin
        if (Start) begin
          state_d = ISSUE;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the edge that enters it.
  always_comb begin
    step_req_d  = (state_d == ISSUE) || (state_d == WAIT_ACK);
    init_d      = (state_d != DONE);
    done_d      = (state_d == DONE);
    fail_d      = (state_d == FAIL);
    retry_cnt_d = (32'(retry_d) >= 32'd3) ? 2'd3 : 2'(retry_d);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      step_req_q  <= 1'b0;
      init_q      <= 1'b1;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      retry_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      step_req_q  <= step_req_d;
      init_q      <= init_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign Step_Req  = step_req_q;
  assign Step_Idx  = idx_q;
  assign INIT      = init_q;
  assign Init_Done = done_q;
  assign Init_Fail = fail_q;
  assign Retry_Cnt = retry_cnt_q;

endmodule

// File: tb/tb_init_sequencer.sv
// tb/tb_init_sequencer.sv - directed and randomized bench for init_sequencer
// Expected timing comes from an edge-count model of the step/retry rules.
module tb_init_sequencer;

  localparam int N   = 3;
  localparam int IW  = 4;
  localparam int PWR = 8;
  localparam int GAP = 2;
  localparam int TO  = 20;
  localparam int MR  = 2;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Step_Ack = 1'b0;
  logic          Step_Err = 1'b0;
  logic          Step_Req;
  logic [IW-1:0] Step_Idx;
  logic          INIT;
  logic          Init_Done;
  logic          Init_Fail;
  logic [1:0]    Retry_Cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int m_idx;
  int m_retry;
  bit m_done;
  bit m_fail;
  int m_rise;

  init_sequencer #(
    .NUM_STEPS(N), .IDX_W(IW), .PWR_CYC(PWR), .GAP_CYC(GAP),
    .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Step_Ack(Step_Ack), .Step_Err(Step_Err),
    .Step_Req(Step_Req), .Step_Idx(Step_Idx), .INIT(INIT), .Init_Done(Init_Done),
    .Init_Fail(Init_Fail), .Retry_Cnt(Retry_Cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_release();
    m_idx   = 0;
    m_retry = 0;
    m_done  = 0;
    m_fail  = 0;
    m_rise  = cyc + PWR;
  endtask

  // Holds through the settle window while throwing stray Ack/Err/Start at it.
  task automatic powerup_check();
    for (int i = 0; i < PWR; i++) begin
      chk("pwr_req", Step_Req, 0);
      chk("pwr_init", INIT, 1);
      chk("pwr_idx", Step_Idx, 0);
      if (i == 3) begin
        Step_Ack = 1'b1;
        Start    = 1'b1;
      end else if (i == 5) begin
        Step_Ack = 1'b1;
        Step_Err = 1'b1;
      end else begin
        Step_Ack = 1'b0;
        Step_Err = 1'b0;
        Start    = 1'b0;
      end
      @(negedge Clk);
    end
  endtask

  task automatic run_attempt(input int kind, input int d, input bit stray);
    int exp_fall;
    int budget;
    budget = 0;
    while (Step_Req !== 1'b1 && budget < 200) begin
      @(negedge Clk);
      budget++;
    end
    chk("rise_seen", Step_Req, 1);
    chk("rise_cycle", cyc, m_rise);
    chk("req_idx", Step_Idx, m_idx);
    chk("req_retry", Retry_Cnt, m_retry);
    chk("req_init", INIT, 1);
    if (Step_Req !== 1'b1) return;
    if (kind != K_NONE) begin
      repeat (d + 1) @(negedge Clk);
      chk("hold_idx", Step_Idx, m_idx);
      Step_Ack = (kind == K_ACK) || (kind == K_BOTH);
      Step_Err = (kind == K_ERR) || (kind == K_BOTH);
      @(negedge Clk);
      Step_Ack = 1'b0;
      Step_Err = 1'b0;
      exp_fall = m_rise + 2 + d;
    end else begin
      exp_fall = m_rise + 1 + TO;
    end
    budget = 0;
    while (Step_Req === 1'b1 && budget < TO + 10) begin
      @(negedge Clk);
      budget++;
    end
    chk("fall_cycle", cyc, exp_fall);
    if (kind != K_ACK) begin
      if (m_retry < MR) begin
        m_retry++;
        m_rise = exp_fall + GAP;
      end else begin
        m_fail = 1;
      end
    end else begin
      m_retry = 0;
      if (m_idx == N - 1) m_done = 1;
      else begin
        m_idx++;
        m_rise = exp_fall + GAP;
      end
    end
    chk("post_req", Step_Req, 0);
    chk("post_idx", Step_Idx, m_idx);
    chk("post_retry", Retry_Cnt, m_retry);
    chk("post_init", INIT, !m_done);
    chk("post_done", Init_Done, m_done);
    chk("post_fail", Init_Fail, m_fail);
    if (stray && !m_done && !m_fail) begin
      Step_Ack = 1'b1;
      Start    = 1'b1;
      @(negedge Clk);
      Step_Ack = 1'b0;
      Start    = 1'b0;
      chk("stray_idx", Step_Idx, m_idx);
      chk("stray_req", Step_Req, 0);
    end
  endtask

  task automatic do_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("start_req", Step_Req, 1);
    chk("start_idx", Step_Idx, 0);
    chk("start_retry", Retry_Cnt, 0);
    chk("start_init", INIT, 1);
    chk("start_done", Init_Done, 0);
    chk("start_fail", Init_Fail, 0);
    m_idx   = 0;
    m_retry = 0;
    m_done  = 0;
    m_fail  = 0;
    m_rise  = cyc;
  endtask

  initial begin
    int budget;
    int guard;
    int r;
    int kind;
    repeat (3) @(negedge Clk);
    chk("rst_req", Step_Req, 0);
    chk("rst_idx", Step_Idx, 0);
    chk("rst_init", INIT, 1);
    chk("rst_done", Init_Done, 0);
    chk("rst_fail", Init_Fail, 0);
    chk("rst_retry", Retry_Cnt, 0);

    Reset = 1'b1;
    model_release();
    powerup_check();

    // Happy path, ack sampled three edges after each request rises.
    for (int i = 0; i < N; i++) run_attempt(K_ACK, 1, i == 0);

    do_start();
    run_attempt(K_ACK, 2, 0);
    run_attempt(K_ERR, 1, 1);
    run_attempt(K_ACK, 0, 0);
    run_attempt(K_ACK, 4, 0);

    do_start();
    run_attempt(K_ACK, 1, 0);
    run_attempt(K_ACK, 1, 0);
    run_attempt(K_NONE, 0, 0);
    run_attempt(K_BOTH, 2, 0);
    run_attempt(K_ACK, 1, 0);

    do_start();
    run_attempt(K_ERR, 0, 0);
    run_attempt(K_ERR, 3, 0);
    run_attempt(K_ERR, 1, 0);
    chk("exh_retry", Retry_Cnt, 2);
    chk("exh_idx", Step_Idx, 0);

    do_start();
    run_attempt(K_ACK, 1, 0);

    budget = 0;
    while (Step_Req !== 1'b1 && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    repeat (2) @(negedge Clk);
    chk("mid_req", Step_Req, 1);
    chk("mid_idx", Step_Idx, 1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_req", Step_Req, 0);
    chk("arst_idx", Step_Idx, 0);
    chk("arst_init", INIT, 1);
    chk("arst_retry", Retry_Cnt, 0);
    @(negedge Clk);
    Reset = 1'b1;
    model_release();
    powerup_check();
    for (int i = 0; i < N; i++) run_attempt(K_ACK, $urandom_range(0, 4), 1);

    for (int s = 0; s < 4; s++) begin
      do_start();
      guard = 0;
      while (!m_done && !m_fail && guard < 40) begin
        r = $urandom_range(0, 9);
        kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
        run_attempt(kind, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        guard++;
      end
      chk("rand_end", (m_done || m_fail) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Parametrised successor to the single-handshake codec init FSM.
- Holds the system in INIT while it waits a power-up settle time, then steps through NUM_STEPS configuration steps (e.g. codec register writes) over a req/ack handshake with the serial config writer.
- Adds per-step timeout, bounded retry, inter-step settle delay, failure reporting and software re-init.
- Sits between top-level reset and the codec config writer; INIT gates the audio datapath exactly as before.

Parameters:
- NUM_STEPS, 10, number of configuration steps; Step_Idx runs 0..NUM_STEPS-1.
- IDX_W, 4, width of Step_Idx; must satisfy 2^IDX_W >= NUM_STEPS.
- PWR_CYC, 1000, Clk cycles of power-up settle before step 0 after reset.
- GAP_CYC, 16, idle Clk cycles between a successful step and the next request.
- TIMEOUT_CYC, 50000, max cycles in WAIT_ACK before the attempt counts as an error.
- MAX_RETRY, 3, retries allowed per step after the first failed attempt.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  re-init request pulse; honoured only in DONE or FAIL.
- Step_Ack  in  1  config writer finished the current step successfully.
- Step_Err  in  1  config writer failed the current step (e.g. NACK).
- Step_Req  out  1  request to execute step Step_Idx.
- Step_Idx  out  IDX_W  index of the current step.
- INIT  out  1  high whenever configuration is not complete (all states except DONE).
- Init_Done  out  1  high in DONE.
- Init_Fail  out  1  high in FAIL.
- Retry_Cnt  out  2  retries consumed on the current step (saturates at 3).

Behaviour:
- Reset low, at any time including mid-handshake:
  - state = PWR_WAIT, counter = 0, Step_Idx = 0, Retry_Cnt = 0.
  - Step_Req = 0, INIT = 1, Init_Done = 0, Init_Fail = 0.
- All outputs are registered, so each changes on the Clk edge that enters the new state.
- PWR_WAIT:
  - count PWR_CYC cycles, then go to ISSUE.
  - Step_Ack and Step_Err are ignored.
- ISSUE: one cycle; assert Step_Req, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - Step_Req stays high; Step_Idx is held stable.
  - Step_Err = 1 (including when Step_Ack is also 1; Err wins) -> error path.
  - Step_Ack = 1 alone -> drop Step_Req next cycle, Retry_Cnt = 0.
    - If Step_Idx == NUM_STEPS-1, go to DONE.
    - Otherwise Step_Idx += 1 and go to GAP.
  - Timeout counter reaches TIMEOUT_CYC-1 with neither input set -> error path.
- Error path:
  - drop Step_Req.
  - If Retry_Cnt < MAX_RETRY: Retry_Cnt += 1, go to GAP, then ISSUE with the same Step_Idx.
  - Otherwise go to FAIL; Step_Idx keeps the failing index.
- GAP: count GAP_CYC cycles, then go to ISSUE. GAP_CYC = 0 means go straight to ISSUE next cycle.
- DONE: INIT = 0, Init_Done = 1, Step_Req = 0.
- FAIL: INIT = 1, Init_Fail = 1, Step_Req = 0; stays until Start or Reset.
- Start:
  - In DONE or FAIL, a Start pulse clears Step_Idx, Retry_Cnt and the flags and goes to ISSUE (PWR_WAIT is skipped). INIT returns to 1 on that edge.
  - Start in any other state is ignored.
- Step_Ack and Step_Err are ignored outside WAIT_ACK; a stray pulse must not advance Step_Idx.
- Counters are sized from their parameters with $clog2 and must not wrap before their terminal count.

Test Plan:
- Parameters NUM_STEPS=3, PWR_CYC=8, GAP_CYC=2, TIMEOUT_CYC=20, MAX_RETRY=2 for all scenarios.
- Power-up, happy path:
  - Stimulus: release Reset; Step_Ack pulses 3 cycles after each Step_Req rises.
  - Required: INIT=1 and Step_Req=0 for 8 cycles after release.
  - Required: Step_Idx steps 0,1,2 with a 2-cycle gap between requests.
  - Required: after the third ack, INIT=0 and Init_Done=1.
- Retry then success:
  - Stimulus: Step_Err on step 1's first attempt, Step_Ack on the second.
  - Required: Retry_Cnt=1 and Step_Idx=1 reissued after the gap; Retry_Cnt back to 0 on ack; sequence completes.
- Retry exhaustion:
  - Stimulus: Step_Err on every attempt of step 0.
  - Required: 3 requests total, then Init_Fail=1, INIT=1, Step_Idx=0, Retry_Cnt=2.
  - Required: Start -> Step_Req next cycle with Step_Idx=0, flags cleared.
- Timeout and simultaneous inputs:
  - Stimulus: never ack step 2.
  - Required: Step_Req drops after 20 cycles and Retry_Cnt increments.
  - Stimulus: on the retry, Step_Ack and Step_Err high together.
  - Required: treated as error, Retry_Cnt=2.
- Reset mid-handshake:
  - Stimulus: assert Reset asynchronously while Step_Req=1 in WAIT_ACK on step 1.
  - Required: Step_Req=0, Step_Idx=0, INIT=1 immediately, without waiting for a Clk edge; the PWR_WAIT wait of 8 cycles repeats.
- Stray and ignored inputs:
  - Stimulus: Step_Ack during GAP and PWR_WAIT.
  - Required: Step_Idx unchanged.
  - Stimulus: Start while busy.
  - Required: no effect.
